// File: rtl/multicycle_control_fsm_if.sv
// +--------------------------------------------------------------------+
// | multicycle_control_fsm_if: request/ready port to the unified memory |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface multicycle_control_fsm_if;
  logic mem_req;
  logic mem_write;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output i_or_d, input mem_ready);
  modport slave  (input mem_req, input mem_write, input i_or_d, output mem_ready);
endinterface

`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
// +--------------------------------------------------------------------+
// | multicycle_control_fsm: RV32I multi-cycle control sequencer         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [6:0]                opcode,
  input  logic                      alu_bcond,
  input  logic                      halt_cond,
  multicycle_control_fsm_if.master  mem,
  output logic                      ir_write,
  output logic                      mdr_write,
  output logic                      aluout_write,
  output logic                      alu_src_a,
  output logic [1:0]                alu_src_b,
  output logic [1:0]                alu_op,
  output logic                      reg_write,
  output logic [1:0]                wb_sel,
  output logic                      pc_write,
  output logic                      pc_source,
  output logic                      is_halted,
  output logic                      fault,
  output logic [2:0]                state,
  output logic [CNT_W-1:0]          instret
);

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  localparam logic [6:0] C_OP_R      = 7'b0110011;
  localparam logic [6:0] C_OP_IMM    = 7'b0010011;
  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_SYSTEM = 7'b1110011;

  localparam int              WAIT_W     = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT > 0);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   instret_q, instret_d;

  logic req_c, wr_c, iod_c, irw_c, mdrw_c, aow_c, rw_c, pcw_c, halt_ret_c;

  always_comb begin
    state_d      = state_q;
    req_c        = 1'b0;
    wr_c         = 1'b0;
    iod_c        = 1'b0;
    irw_c        = 1'b0;
    mdrw_c       = 1'b0;
    aow_c        = 1'b0;
    rw_c         = 1'b0;
    pcw_c        = 1'b0;
    halt_ret_c   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'd0;
    alu_op       = 2'd0;
    wb_sel       = 2'd0;
    pc_source    = 1'b0;

    case (state_q)
      S_IF: begin
        req_c = 1'b1;
        if (mem.mem_ready) begin
          irw_c   = 1'b1;
          state_d = S_ID;
        end
      end
      // Speculatively form PC+imm so JAL and branches find their target in ALUOut.
      S_ID: begin
        aow_c     = 1'b1;
        alu_src_b = 2'd2;
        case (opcode)
          C_OP_JAL: state_d = S_WB;
          C_OP_SYSTEM: begin
            if (halt_cond) begin
              halt_ret_c = 1'b1;
              state_d    = S_HALT;
            end else begin
              pcw_c   = 1'b1;
              state_d = S_IF;
            end
          end
          C_OP_R, C_OP_IMM, C_OP_LUI, C_OP_AUIPC, C_OP_LOAD,
          C_OP_STORE, C_OP_JALR, C_OP_BRANCH: state_d = S_EX;
          default: state_d = S_FAULT;
        endcase
      end
      S_EX: begin
        aow_c   = 1'b1;
        state_d = S_WB;
        case (opcode)
          C_OP_R:      begin alu_src_a = 1'b1; alu_src_b = 2'd0; alu_op = 2'd2; end
          C_OP_IMM:    begin alu_src_a = 1'b1; alu_src_b = 2'd2; alu_op = 2'd2; end
          C_OP_LUI:    begin alu_src_b = 2'd2; alu_op = 2'd3; end
          C_OP_AUIPC:  begin alu_src_b = 2'd2; alu_op = 2'd0; end
          C_OP_JALR:   begin alu_src_a = 1'b1; alu_src_b = 2'd2; alu_op = 2'd0; end
          C_OP_LOAD, C_OP_STORE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_d   = S_MEM;
          end
          C_OP_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'd1;
            aow_c     = 1'b0;
            pcw_c     = 1'b1;
            pc_source = alu_bcond;
            state_d   = S_IF;
          end
          default: begin
            aow_c   = 1'b0;
            state_d = S_FAULT;
          end
        endcase
      end
      S_MEM: begin
        req_c = 1'b1;
        iod_c = 1'b1;
        wr_c  = (opcode == C_OP_STORE);
        if (mem.mem_ready) begin
          if (opcode == C_OP_STORE) begin
            pcw_c   = 1'b1;
            state_d = S_IF;
          end else begin
            mdrw_c  = 1'b1;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rw_c    = 1'b1;
        pcw_c   = 1'b1;
        state_d = S_IF;
        if (opcode == C_OP_LOAD) begin
          wb_sel = 2'd1;
        end else if (opcode == C_OP_JAL || opcode == C_OP_JALR) begin
          wb_sel    = 2'd2;
          pc_source = 1'b1;
        end
      end
      default: state_d = state_q;
    endcase

    // A ready arriving on the limit cycle still wins over the timeout.
    if (TIMEOUT_EN && req_c && !mem.mem_ready && wait_q == WAIT_LIMIT) begin
      state_d = S_FAULT;
    end

    if (state_d != state_q && (state_d == S_IF || state_d == S_MEM)) begin
      wait_d = '0;
    end else if (TIMEOUT_EN && req_c && !mem.mem_ready && wait_q != WAIT_LIMIT) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = wait_q;
    end

    instret_d = instret_q + CNT_W'(pcw_c | halt_ret_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IF;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  assign mem.mem_req   = req_c  & ~reset;
  assign mem.mem_write = wr_c   & ~reset;
  assign mem.i_or_d    = iod_c;
  assign ir_write      = irw_c  & ~reset;
  assign mdr_write     = mdrw_c & ~reset;
  assign aluout_write  = aow_c  & ~reset;
  assign reg_write     = rw_c   & ~reset;
  assign pc_write      = pcw_c  & ~reset;
  assign is_halted     = (state_q == S_HALT);
  assign fault         = (state_q == S_FAULT);
  assign state         = state_q;
  assign instret       = instret_q;

endmodule

`default_nettype wire

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multi-cycle control unit for the RV32I core. It replaces the single-cycle core's combinational control decode with a state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It talks to one shared memory through a ready handshake, counts retired instructions and detects memory timeouts. It sits between the instruction register, ALU, register file and unified memory of the multi-cycle datapath.

## Interface
Parameters:
- MEM_TIMEOUT, 16: consecutive wait cycles allowed on a memory request before entering FAULT. 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  7  instruction register [6:0], valid from ID onward
- alu_bcond  in  1  branch condition from ALU, valid in EX of a branch
- halt_cond  in  1  register x17 == 10, from the register file
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_write  out  1  request is a store
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR (and MDR) from memory data
- mdr_write  out  1  load MDR from memory data
- aluout_write  out  1  latch ALU result into ALUOut
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs1 register A
- alu_src_b  out  2  ALU B select: 0 = rs2 register B, 1 = constant 4, 2 = immediate
- alu_op  out  2  ALU operation: 0 = add, 1 = branch compare, 2 = funct decode, 3 = pass B
- reg_write  out  1  register file write enable
- wb_sel  out  2  writeback select: 0 = ALUOut, 1 = MDR, 2 = PC+4
- pc_write  out  1  update PC
- pc_source  out  1  next PC select: 0 = PC+4, 1 = ALUOut
- is_halted  out  1  sticky halt
- fault  out  1  sticky fault
- state  out  3  current state, for debug
- instret  out  CNT_W  retired-instruction count

## Operation
- State encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, FAULT=6.
- Outputs are combinational from state, opcode, mem_ready and alu_bcond. Any output not named for a state is 0.
- IF: mem_req=1, i_or_d=0. On mem_ready: ir_write=1, go to ID.
- ID: alu_src_a=0, alu_src_b=2, alu_op=0, aluout_write=1, so ALUOut = PC+imm.
  - JAL goes to WB.
  - ECALL with halt_cond=1 goes to HALT; ECALL with halt_cond=0 sets pc_write=1, pc_source=0 and returns to IF.
  - Unknown opcode goes to FAULT.
  - All other opcodes go to EX.
- EX (aluout_write=1 unless noted):
  - R-type: a=1, b=0, op=2, then WB.
  - I-ALU: a=1, b=2, op=2, then WB.
  - LUI: b=2, op=3, then WB.
  - AUIPC: a=0, b=2, op=0, then WB.
  - Load and store: a=1, b=2, op=0, then MEM.
  - JALR: a=1, b=2, op=0, then WB. The datapath clears the LSB of the target.
  - Branch: a=1, b=0, op=1, aluout_write=0, pc_write=1, pc_source=alu_bcond, then IF.
- MEM: mem_req=1, i_or_d=1, mem_write=1 for stores.
  - Load completes on mem_ready with mdr_write=1, then WB.
  - Store completes on mem_ready with pc_write=1, pc_source=0, then IF.
- WB: reg_write=1, pc_write=1, then IF.
  - Load: wb_sel=1.
  - JAL and JALR: wb_sel=2, pc_source=1.
  - All others: wb_sel=0, pc_source=0.
- HALT and FAULT are absorbing until reset. All strobes are 0. is_halted or fault is 1 respectively.
- Retire: every cycle with pc_write=1, and the ECALL cycle that enters HALT, increments instret by 1. instret wraps modulo 2^CNT_W.
- Timeout: a wait counter clears on entering IF or MEM and increments each cycle mem_ready=0 while mem_req=1.
  - With MEM_TIMEOUT>0, when the counter equals MEM_TIMEOUT and mem_ready=0, the next state is FAULT.
  - If mem_ready=1 on that same cycle, the request completes normally.

## Timing
- Reset (asynchronous): state=IF, instret=0, wait counter=0, is_halted=0, fault=0.
- While reset=1, all strobes are forced to 0 (mem_req, ir_write, mdr_write, pc_write, reg_write, mem_write, aluout_write).
- The first mem_req is in the first cycle after reset is deasserted.
- Zero-wait cycle counts (mem_ready=1 in the request cycle):
  - R, I-ALU, LUI, AUIPC, JALR: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - JAL: 3 cycles.
  - Non-halting ECALL: 2 cycles.
- Each memory wait cycle adds 1 cycle. mem_req, i_or_d and mem_write stay stable until mem_ready.
- Reset asserted mid-instruction aborts it immediately. No partial pc_write or reg_write occurs after the reset edge.

## Test plan
- R-type ADD, zero-wait memory: state sequence 0,1,2,4,0. reg_write and pc_write are 1 only in cycle 4. instret goes 0→1.
- Load with mem_ready low for 3 cycles in MEM: MEM lasts 4 cycles, mdr_write is asserted only in the last one, WB selects wb_sel=1. Total 8 cycles.
- Branch, alu_bcond=1 then alu_bcond=0: EX asserts pc_write with pc_source=1, then with pc_source=0. Each takes 3 cycles, and WB is never entered.
- MEM_TIMEOUT=4, mem_ready held 0 in IF: after 5 cycles with mem_req=1, fault=1 and state=6 sticky. Reset returns state to 0 and fault to 0.
- ECALL with halt_cond=1 after 2 retired instructions: is_halted=1, instret=3, no further mem_req. With halt_cond=0 instead: pc_write=1 in ID and fetch continues.
- CNT_W=4: 16 retirements wrap instret from 15 to 0. Asserting reset in EX clears state and instret asynchronously, with no reg_write.
